// File: rtl/tff_pkg.sv
// Shared constants and helpers for the T flip-flop counter family.
// Direction encoding and a constant-foldable ceil(log2) for parameter checks.
package tff_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop with asynchronous active-low clear.
// Latency: toggles on the rising edge after t is sampled high.
// Backpressure: none; free-running storage cell.
module tff_cell (
    input  logic clk,
    input  logic reset,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/tff_counter.sv
// Up/down modulo counter with load, wrap/saturate and a terminal-count pulse.
// Latency: q and tc update one edge after the inputs are sampled; no comb path.
// Backpressure: none; load overrides en, en=0 holds the count.
module tff_counter
    import tff_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
        $error("tff_counter: WIDTH must be in 1..16");
    end
    if (MODULUS < 2 || clog2(MODULUS) > WIDTH) begin : g_bad_modulus
        $error("tff_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end

    logic [WIDTH-1:0] nq;
    logic [WIDTH-1:0] t;
    logic             nxt_tc;

    always_comb begin
        nq     = q;
        nxt_tc = 1'b0;
        if (load) begin
            nq = ({1'b0, din} < MOD_EXT) ? din : MAX_Q;
        end else if (en) begin
            case (up)
                DIR_UP: begin
                    if (q == MAX_Q) begin
                        nxt_tc = 1'b1;
                        nq     = SATURATE ? q : '0;
                    end else begin
                        nq = q + WIDTH'(1);
                    end
                end
                DIR_DN: begin
                    if (q == '0) begin
                        nxt_tc = 1'b1;
                        nq     = SATURATE ? q : MAX_Q;
                    end else begin
                        nq = q - WIDTH'(1);
                    end
                end
                default: nq = q;
            endcase
        end
    end

    // Only bits that change are toggled; the cells have no direct D input.
    assign t = q ^ nq;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clk  (clk),
            .reset(reset),
            .t    (t[i]),
            .q    (q[i])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tc <= 1'b0;
        end else begin
            tc <= nxt_tc;
        end
    end

endmodule

// File: tb/tb_tff_counter.sv
// Bench for tff_counter: wrap (4b/10), saturate (4b/10) and full-range (3b/8) instances.
module tb_tff_counter;

    logic       clk;
    logic       reset;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] din;
    logic [3:0] qa;
    logic       tca;
    logic [3:0] qs;
    logic       tcs;
    logic [2:0] qb;
    logic       tcb;

    int n_tests = 0;
    int n_fail  = 0;
    int ma = 0;
    int ms = 0;
    int mb = 0;

    typedef struct {
        int qa;
        bit tca;
        int qs;
        bit tcs;
        int qb;
        bit tcb;
    } exp_t;

    typedef struct {
        bit       en;
        bit       up;
        bit       load;
        bit [3:0] din;
        int       exp_q;
        bit       exp_tc;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];

    tff_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .din(din), .q(qa), .tc(tca)
    );

    tff_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_sat (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .din(din), .q(qs), .tc(tcs)
    );

    tff_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(1'b0)) u_full (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .din(din[2:0]), .q(qb), .tc(tcb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endtask

    // Behavioural reference for one counter instance.
    function automatic void step(input int m, input bit sat, input int cur,
                                 input bit e, input bit u, input bit l, input int d,
                                 output int nq, output bit ntc);
        nq  = cur;
        ntc = 1'b0;
        if (l) begin
            nq = (d < m) ? d : m - 1;
        end else if (e && u) begin
            if (cur == m - 1) begin
                ntc = 1'b1;
                nq  = sat ? cur : 0;
            end else begin
                nq = cur + 1;
            end
        end else if (e) begin
            if (cur == 0) begin
                ntc = 1'b1;
                nq  = sat ? cur : m - 1;
            end else begin
                nq = cur - 1;
            end
        end
    endfunction

    task automatic drive(input bit e, input bit u, input bit l, input bit [3:0] d,
                         input string nm);
        exp_t x;
        @(negedge clk);
        en   = e;
        up   = u;
        load = l;
        din  = d;
        step(10, 1'b0, ma, e, u, l, int'(d), x.qa, x.tca);
        step(10, 1'b1, ms, e, u, l, int'(d), x.qs, x.tcs);
        step(8, 1'b0, mb, e, u, l, int'(d) & 7, x.qb, x.tcb);
        ma = x.qa;
        ms = x.qs;
        mb = x.qb;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check({nm, " wrap q"}, int'(qa), x.qa);
        check({nm, " wrap tc"}, int'(tca), int'(x.tca));
        check({nm, " sat q"}, int'(qs), x.qs);
        check({nm, " sat tc"}, int'(tcs), int'(x.tcs));
        check({nm, " full q"}, int'(qb), x.qb);
        check({nm, " full tc"}, int'(tcb), int'(x.tcb));
    endtask

    task automatic check_cleared(input string nm);
        check({nm, " wrap q"}, int'(qa), 0);
        check({nm, " wrap tc"}, int'(tca), 0);
        check({nm, " sat q"}, int'(qs), 0);
        check({nm, " sat tc"}, int'(tcs), 0);
        check({nm, " full q"}, int'(qb), 0);
        check({nm, " full tc"}, int'(tcb), 0);
    endtask

    function automatic vec_t mk(input bit e, input bit u, input bit l, input bit [3:0] d,
                                input int eq, input bit etc);
        vec_t v;
        v.en = e; v.up = u; v.load = l; v.din = d; v.exp_q = eq; v.exp_tc = etc;
        return v;
    endfunction

    initial begin
        int s_q[3];
        int s_tc[3];
        int b_q[6];
        int b_tc[6];

        reset = 1'b0;
        en    = 1'b0;
        up    = 1'b1;
        load  = 1'b0;
        din   = 4'd0;
        #3;
        check_cleared("por");
        @(negedge clk);
        reset = 1'b1;

        // Async clear mid-count, observed between edges.
        drive(1'b0, 1'b1, 1'b1, 4'd7, "ld7");
        check("ld7 explicit", int'(qa), 7);
        #2;
        reset = 1'b0;
        #1;
        check_cleared("midreset");
        ma = 0; ms = 0; mb = 0;
        en   = 1'b0;
        load = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 4'd0, "rel_up");
        check("rel_up explicit", int'(qa), 1);

        // Expected values below are for the wrap instance, starting from q=1.
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 4'd0, 0, 1'b0));
        for (int k = 1; k <= 9; k++) tbl.push_back(mk(1'b1, 1'b1, 1'b0, 4'd0, k, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 4'd0, 0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 4'd0, 9, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 4'd0, 8, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 4'd13, 9, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 4'd0, 0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 4'd0, 0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 4'd0, 9, 1'b1));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 4'd0, 0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 4'd3, 3, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 4'd0, 4, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 4'd0, 3, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 4'd15, 9, 1'b0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].en, tbl[i].up, tbl[i].load, tbl[i].din, $sformatf("vec%0d", i));
            check($sformatf("vec%0d table q", i), int'(qa), tbl[i].exp_q);
            check($sformatf("vec%0d table tc", i), int'(tca), int'(tbl[i].exp_tc));
        end

        // Saturating instance pinned at the top of the range.
        s_q  = '{9, 9, 9};
        s_tc = '{0, 1, 1};
        drive(1'b0, 1'b1, 1'b1, 4'd8, "s_ld8");
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 1'b0, 4'd0, $sformatf("s_up%0d", k));
            check($sformatf("s_up%0d explicit q", k), int'(qs), s_q[k]);
            check($sformatf("s_up%0d explicit tc", k), int'(tcs), s_tc[k]);
        end
        drive(1'b0, 1'b1, 1'b1, 4'd0, "s_ld0");
        drive(1'b1, 1'b0, 1'b0, 4'd0, "s_dn");
        check("s_dn explicit q", int'(qs), 0);
        check("s_dn explicit tc", int'(tcs), 1);

        // Full-range instance with en toggling every cycle.
        b_q  = '{6, 6, 7, 7, 0, 0};
        b_tc = '{0, 0, 0, 0, 1, 0};
        drive(1'b0, 1'b1, 1'b1, 4'd5, "b_ld5");
        for (int k = 0; k < 6; k++) begin
            drive((k % 2) == 0, 1'b1, 1'b0, 4'd0, $sformatf("b_tog%0d", k));
            check($sformatf("b_tog%0d explicit q", k), int'(qb), b_q[k]);
            check($sformatf("b_tog%0d explicit tc", k), int'(tcb), b_tc[k]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
